pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic inter-stage pipeline register for the superscalar pipeline (RF/EX, EX/MEM, MEM/WB boundaries).
- Carries LANES independent instruction slots, each with a valid bit and a DATA_W-bit payload.
- Provides a valid/ready handshake with a 2-entry skid buffer, so in_ready is purely registered.
- Provides whole-stage flush and per-lane squash (kill) from branch/hazard logic.

Parameters:
- LANES, 2, instruction slots per group (issue width)
- DATA_W, 96, payload bits per lane (packed control + operands + dest)
- CNT_W, 16, stall counter width (optional feature only)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  discard all held and incoming groups
- kill_mask  in  LANES  clear the matching lanes of held groups
- in_valid  in  1  upstream group valid
- in_ready  out  1  stage can accept a group this cycle
- in_lane_valid  in  LANES  per-lane valid of the incoming group
- in_data  in  LANES*DATA_W  incoming payload; lane i at [i*DATA_W +: DATA_W]
- out_valid  out  1  presented group has at least one live lane
- out_ready  in  1  downstream accepts
- out_lane_valid  out  LANES  live lanes of the presented group
- out_data  out  LANES*DATA_W  presented payload (main register)
- occupancy  out  2  0, 1 or 2 groups held
- stall_cnt  out  CNT_W  present only with PIPE_STALL_CNT_EN

Behaviour:
- Reset is sampled only on the rising clock edge. When reset=0:
  - state goes to EMPTY.
  - All lane-valid bits, main/skid payloads and stall_cnt are cleared to 0.
  - Outputs then read in_ready=1, out_valid=0, out_lane_valid=0, out_data=0 and occupancy=0.
- Reset overrides flush, accept and fire.
- States:
  - EMPTY: occupancy 0.
  - FULL: main register holds a group; occupancy 1.
  - SKID: main and skid registers both hold groups; occupancy 2.
- in_ready = (state != SKID). It is registered and has no combinational path from out_ready.
- Combinational outputs:
  - out_lane_valid = main_lv & ~kill_mask.
  - out_valid = |out_lane_valid.
- accept = in_valid & in_ready & ~flush & (|in_lane_valid).
  - A group with all lanes invalid is consumed but never stored (bubble collapse).
- fire = out_valid & out_ready.
- Transitions, with kill applied first: main_lv' = main_lv & ~kill_mask and skid_lv' = skid_lv & ~kill_mask.
  - EMPTY:
    - accept -> FULL; main <= in.
  - FULL:
    - accept & fire -> FULL; main <= in.
    - accept & ~fire & |main_lv' -> SKID; skid <= in.
    - accept & ~|main_lv' -> FULL; main <= in (a dead main is replaced).
    - ~accept & (fire | ~|main_lv') -> EMPTY.
    - otherwise stay; main_lv <= main_lv'.
  - SKID:
    - fire or ~|main_lv' -> promote skid to main. If |skid_lv' the result is FULL, otherwise EMPTY.
    - otherwise stay with both registers masked.
- A killed group (all lanes killed) is never presented with out_valid=1.
- flush=1 -> next state is EMPTY and all lane-valid bits are cleared. Payload registers keep their values.
  - A fire in the same cycle still counts downstream.
  - An incoming group in the same cycle is dropped.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 group per cycle while out_ready=1.
- Payload order is strictly FIFO. Lanes are never reordered or compacted within a group.

Optional Feature:
PIPE_STALL_CNT_EN:
- Defined:
  - stall_cnt increments by 1 every cycle in which out_valid=1 and out_ready=0.
  - It saturates at 2^CNT_W-1.
  - It is cleared by reset only; flush does not clear it.
- Undefined:
  - The stall_cnt port and its counter logic are absent.

Decomposition:
- Package pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_FULL, ST_SKID);
  - default LANES and DATA_W;
  - the per-stage payload field offsets used to pack in_data.
- One natural sub-module is pipe_lane_slot: one lane-valid bit plus DATA_W payload, with load, kill and clear. It is instantiated LANES times each for main and skid.

Test Plan:
- Flow: LANES=2, out_ready=1, groups A,B,C on consecutive cycles.
  - out_data shows A,B,C on cycles 1,2,3; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0 while A then B are accepted.
  - occupancy=2 and in_ready=0. In_valid group C is held off.
  - Raising out_ready drains A, then B, then C in order with no loss.
- Kill: held group with lane_valid=11, kill_mask=01.
  - out_lane_valid=10 that cycle.
  - Then kill_mask=10 -> out_valid=0 and the group is removed. If the skid holds a group, it is presented next.
- Bubble: in_valid=1 with in_lane_valid=00 -> occupancy unchanged and out_valid stays 0.
- Flush in SKID with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, and the incoming group is not stored.
- Reset: reset=0 for one edge while in SKID.
  - All outputs are zero and in_ready=1.
  - With PIPE_STALL_CNT_EN, stall_cnt=0 after 5 earlier stalled cycles had reached 5.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, default geometry and payload field layout for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam int DEF_LANES  = 2;
    localparam int DEF_DATA_W = 96;

    localparam int CTRL_OFF = 0;
    localparam int CTRL_W   = 16;
    localparam int SRCA_OFF = 16;
    localparam int SRCB_OFF = 48;
    localparam int SRC_W    = 32;
    localparam int DEST_OFF = 80;
    localparam int DEST_W   = 16;

    function automatic logic [1:0] occ_of(state_e s);
        return s == ST_SKID ? 2'd2 : s == ST_FULL ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_lane_slot.sv
// pipe_lane_slot: one lane-valid bit plus its payload, with load, kill and clear
module pipe_lane_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              kill_i,
    input  logic              lv_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              lv_o,
    output logic [DATA_W-1:0] data_o
);

    logic              lv_q;
    logic [DATA_W-1:0] data_q;

    // clear drops only the valid bit; the payload is left as it was
    always_ff @(posedge clock) begin
        if (!reset) begin
            lv_q   <= 1'b0;
            data_q <= '0;
        end else begin
            lv_q <= !clear_i && (load_i ? lv_i : lv_q && !kill_i);
            if (load_i && !clear_i) data_q <= data_i;
        end
    end

    assign lv_o   = lv_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic multi-lane pipeline register with 2-entry skid, flush and per-lane kill.
// Defining PIPE_STALL_CNT_EN adds the saturating stall_cnt output.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W
`ifdef PIPE_STALL_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [LANES-1:0]        kill_mask,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [1:0]              occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]        stall_cnt
`endif
);

    state_e                  state_q, state_d;
    logic                    in_ready_q;
    logic [1:0]              occ_q;
    logic [LANES-1:0]        main_lv, skid_lv;
    logic [LANES*DATA_W-1:0] main_data, skid_data;
    logic                    accept, fire, main_live, skid_live;
    logic                    main_load, main_from_skid, main_clr, skid_load, skid_clr;

    assign out_lane_valid = main_lv & ~kill_mask;
    assign out_valid      = |out_lane_valid;
    assign out_data       = main_data;
    assign in_ready       = in_ready_q;
    assign occupancy      = occ_q;
    assign accept         = in_valid && in_ready_q && !flush && |in_lane_valid;
    assign fire           = out_valid && out_ready;
    assign main_live      = |(main_lv & ~kill_mask);
    assign skid_live      = |(skid_lv & ~kill_mask);

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = flush;
        skid_load      = 1'b0;
        skid_clr       = flush;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    main_load = accept;
                    state_d   = accept ? ST_FULL : ST_EMPTY;
                end
                ST_FULL: begin
                    // a dead main is overwritten rather than parked behind the skid
                    main_load = accept && (fire || !main_live);
                    skid_load = accept && !fire && main_live;
                    main_clr  = !accept && (fire || !main_live);
                    state_d   = skid_load ? ST_SKID : main_clr ? ST_EMPTY : ST_FULL;
                end
                ST_SKID: begin
                    main_load      = fire || !main_live;
                    main_from_skid = main_load;
                    skid_clr       = main_load;
                    state_d        = !main_load ? ST_SKID : skid_live ? ST_FULL : ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != ST_SKID;
            occ_q      <= occ_of(state_d);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pipe_lane_slot #(.DATA_W(DATA_W)) u_main (
            .clock  (clock),
            .reset  (reset),
            .load_i (main_load),
            .clear_i(main_clr),
            .kill_i (kill_mask[l]),
            .lv_i   (main_from_skid ? skid_lv[l] && !kill_mask[l] : in_lane_valid[l]),
            .data_i (main_from_skid ? skid_data[l*DATA_W +: DATA_W] : in_data[l*DATA_W +: DATA_W]),
            .lv_o   (main_lv[l]),
            .data_o (main_data[l*DATA_W +: DATA_W])
        );
        pipe_lane_slot #(.DATA_W(DATA_W)) u_skid (
            .clock  (clock),
            .reset  (reset),
            .load_i (skid_load),
            .clear_i(skid_clr),
            .kill_i (kill_mask[l]),
            .lv_i   (in_lane_valid[l]),
            .data_i (in_data[l*DATA_W +: DATA_W]),
            .lv_o   (skid_lv[l]),
            .data_o (skid_data[l*DATA_W +: DATA_W])
        );
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clock) begin
        if (!reset) stall_cnt_q <= '0;
        else if (out_valid && !out_ready && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a queue-based model
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int L = 2;
    localparam int W = 96;
    typedef logic [L*W-1:0] wide_t;
    typedef struct {
        logic [L-1:0] lv;
        wide_t        d;
    } grp_t;

    logic         clock = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [L-1:0] kill_mask = '0, in_lane_valid = '0;
    wide_t        in_data = '0;
    logic         in_ready, out_valid;
    logic [L-1:0] out_lane_valid;
    wide_t        out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int   checks = 0, errors = 0, sc = 0;
    bit   mon = 1'b0;
    grp_t q[$];

    always #5 clock = ~clock;

    pipe_stage_reg #(.LANES(L), .DATA_W(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .kill_mask     (kill_mask),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_lane_valid (in_lane_valid),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_lane_valid(out_lane_valid),
        .out_data      (out_data),
        .occupancy     (occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic chk(input string n, input wide_t a, input wide_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic wide_t grp(input int t);
        wide_t g = '0;
        for (int l = 0; l < L; l++) begin
            g[l*W+CTRL_OFF +: CTRL_W] = CTRL_W'(t + l);
            g[l*W+SRCA_OFF +: SRC_W]  = SRC_W'(t * 7 + l);
            g[l*W+SRCB_OFF +: SRC_W]  = SRC_W'(t * 13 + l);
            g[l*W+DEST_OFF +: DEST_W] = DEST_W'(l + 1);
        end
        return g;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set(input logic iv, input logic [L-1:0] ilv, input wide_t d,
                       input logic ordy, input logic [L-1:0] k, input logic fl);
        in_valid = iv;
        in_lane_valid = ilv;
        in_data = d;
        out_ready = ordy;
        kill_mask = k;
        flush = fl;
    endtask

    // Model: the stage is a FIFO of at most two groups; dead heads vanish, kills hit every held group
    always @(negedge clock) begin : model
        logic [L-1:0] elv;
        bit acc, fire_m;
        if (mon) begin
            elv = q.size() > 0 ? q[0].lv & ~kill_mask : '0;
            chk("m_in_ready", wide_t'(in_ready), wide_t'(q.size() < 2));
            chk("m_occupancy", wide_t'(occupancy), wide_t'(q.size()));
            chk("m_lane_valid", wide_t'(out_lane_valid), wide_t'(elv));
            chk("m_out_valid", wide_t'(out_valid), wide_t'(|elv));
            if (|elv) chk("m_out_data", out_data, q[0].d);
`ifdef PIPE_STALL_CNT_EN
            chk("m_stall_cnt", wide_t'(stall_cnt), wide_t'(sc));
`endif
            if (!reset) begin
                q.delete();
                sc = 0;
            end else begin
                fire_m = |elv && out_ready;
                acc = in_valid && q.size() < 2 && !flush && |in_lane_valid;
                if (|elv && !out_ready && sc < 65535) sc++;
                if (flush) q.delete();
                else begin
                    foreach (q[i]) q[i].lv = q[i].lv & ~kill_mask;
                    if (fire_m) void'(q.pop_front());
                    while (q.size() > 0 && q[0].lv == '0) void'(q.pop_front());
                    if (acc) q.push_back('{in_lane_valid, in_data});
                end
            end
        end
    end

    initial begin
        tick();
        reset = 1'b1;
        mon = 1'b1;
        chk("rst_in_ready", wide_t'(in_ready), wide_t'(1));
        chk("rst_out_valid", wide_t'(out_valid), wide_t'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_occ", wide_t'(occupancy), wide_t'(0));

        // flow: one group per cycle
        set(1, 2'b11, grp(10), 1, 0, 0); tick();
        chk("flow_a", out_data, grp(10));
        chk("flow_occ", wide_t'(occupancy), wide_t'(1));
        set(1, 2'b11, grp(20), 1, 0, 0); tick();
        chk("flow_b", out_data, grp(20));
        chk("flow_rdy", wide_t'(in_ready), wide_t'(1));
        set(1, 2'b11, grp(30), 1, 0, 0); tick();
        chk("flow_c", out_data, grp(30));
        set(0, 0, '0, 1, 0, 0); tick();
        chk("flow_empty", wide_t'(occupancy), wide_t'(0));

        // backpressure into the skid, then drain in order
        set(1, 2'b11, grp(40), 0, 0, 0); tick();
        set(1, 2'b11, grp(50), 0, 0, 0); tick();
        chk("bp_occ2", wide_t'(occupancy), wide_t'(2));
        chk("bp_rdy0", wide_t'(in_ready), wide_t'(0));
        set(1, 2'b11, grp(60), 0, 0, 0); tick();
        chk("bp_hold_a", out_data, grp(40));
        set(1, 2'b11, grp(60), 1, 0, 0); tick();
        chk("bp_drain_b", out_data, grp(50));
        chk("bp_occ1", wide_t'(occupancy), wide_t'(1));
        tick();
        chk("bp_drain_c", out_data, grp(60));
        set(0, 0, '0, 1, 0, 0); tick();
        chk("bp_empty", wide_t'(occupancy), wide_t'(0));

        // kill one lane, then the rest, exposing the skid group
        set(1, 2'b11, grp(70), 0, 0, 0); tick();
        set(0, 0, '0, 0, 2'b01, 0); #1;
        chk("kill_lv10", wide_t'(out_lane_valid), wide_t'(2'b10));
        tick();
        set(1, 2'b01, grp(80), 0, 0, 0); tick();
        chk("kill_occ2", wide_t'(occupancy), wide_t'(2));
        set(0, 0, '0, 0, 2'b10, 0); #1;
        chk("kill_dead", wide_t'(out_valid), wide_t'(0));
        tick();
        set(0, 0, '0, 0, 0, 0); #1;
        chk("kill_next", out_data, grp(80));
        chk("kill_next_lv", wide_t'(out_lane_valid), wide_t'(2'b01));
        chk("kill_occ1", wide_t'(occupancy), wide_t'(1));
        set(0, 0, '0, 1, 0, 0); tick();

        // bubble collapse, empty and full
        set(1, 2'b00, grp(90), 0, 0, 0); tick();
        chk("bub_occ0", wide_t'(occupancy), wide_t'(0));
        chk("bub_ov0", wide_t'(out_valid), wide_t'(0));
        set(1, 2'b11, grp(100), 0, 0, 0); tick();
        set(1, 2'b00, grp(101), 0, 0, 0); tick();
        chk("bub_occ1", wide_t'(occupancy), wide_t'(1));
        chk("bub_keep", out_data, grp(100));

        // flush from skid and from empty with incoming groups
        set(1, 2'b11, grp(110), 0, 0, 0); tick();
        chk("fl_occ2", wide_t'(occupancy), wide_t'(2));
        set(1, 2'b11, grp(120), 0, 0, 1); tick();
        chk("fl_occ0", wide_t'(occupancy), wide_t'(0));
        chk("fl_ov0", wide_t'(out_valid), wide_t'(0));
        chk("fl_rdy", wide_t'(in_ready), wide_t'(1));
        tick();
        chk("fl_drop", wide_t'(occupancy), wide_t'(0));
        set(0, 0, '0, 0, 0, 0); tick();

        // stall count and reset while in SKID
        reset = 1'b0; tick(); reset = 1'b1;
        set(1, 2'b11, grp(130), 0, 0, 0); tick();
        set(0, 0, '0, 0, 0, 0);
        repeat (5) tick();
`ifdef PIPE_STALL_CNT_EN
        chk("stall5", wide_t'(stall_cnt), wide_t'(5));
`endif
        set(1, 2'b11, grp(140), 0, 0, 0); tick();
        chk("rs_occ2", wide_t'(occupancy), wide_t'(2));
        set(0, 0, '0, 0, 0, 0);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("rs_ov", wide_t'(out_valid), wide_t'(0));
        chk("rs_lv", wide_t'(out_lane_valid), wide_t'(0));
        chk("rs_data", out_data, '0);
        chk("rs_occ", wide_t'(occupancy), wide_t'(0));
        chk("rs_rdy", wide_t'(in_ready), wide_t'(1));
`ifdef PIPE_STALL_CNT_EN
        chk("rs_stall", wide_t'(stall_cnt), wide_t'(0));
`endif

        // randomized traffic against the model
        repeat (3000) begin
            in_valid = $urandom_range(0, 9) < 7;
            in_lane_valid = L'($urandom);
            for (int i = 0; i < L * W / 32; i++) in_data[i*32 +: 32] = $urandom;
            out_ready = $urandom_range(0, 9) < 6;
            kill_mask = $urandom_range(0, 9) == 0 ? L'($urandom) : '0;
            flush = $urandom_range(0, 49) == 0;
            reset = $urandom_range(0, 199) != 0;
            tick();
        end
        set(0, 0, '0, 1, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
